// File: rtl/frame_pixel_reader_if.sv
//------------------------------------------------------------------------------
// Module   : frame_pixel_reader_if
// Brief    : RAM read port and pixel stream bundle used by frame_pixel_reader.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface frame_pixel_reader_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 21
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_sof;
    logic              m_eol;
    logic              m_eof;

    modport master (
        output mem_rd_en, mem_rd_addr,
        input  mem_rd_data,
        output m_valid, m_data, m_sof, m_eol, m_eof,
        input  m_ready
    );

    modport slave (
        input  mem_rd_en, mem_rd_addr,
        output mem_rd_data,
        input  m_valid, m_data, m_sof, m_eol, m_eof,
        output m_ready
    );
endinterface

`default_nettype wire

// File: rtl/frame_pixel_reader.sv
//------------------------------------------------------------------------------
// Module   : frame_pixel_reader
// Brief    : Raster-order frame reader over a 1-cycle RAM port, emitting a
//            valid/ready pixel stream with sof/eol/eof markers.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module frame_pixel_reader #(
    parameter int WIDTH     = 1600,
    parameter int HEIGHT    = 900,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 21,
    parameter int BASE_ADDR = 0
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  start,
    output logic                       busy,
    output logic                       done,
    frame_pixel_reader_if.master       bus
);

    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [XW-1:0]     X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0]     Y_LAST = YW'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sof;
        logic              eol;
        logic              eof;
    } beat_t;

    state_t            state_q;
    logic [XW-1:0]     x_q;
    logic [YW-1:0]     y_q;
    logic [ADDR_W-1:0] addr_q;
    logic              inflight_q;
    logic              sof_q;
    logic              eol_q;
    logic              eof_q;
    beat_t             fifo_q [4];
    logic [1:0]        wr_ptr_q;
    logic [1:0]        rd_ptr_q;
    logic [2:0]        occ_q;

    logic              issue;
    logic              push;
    logic              pop;
    logic              last_pix;
    logic [2:0]        occ_d;
    beat_t             head;
    beat_t             push_beat;

    // Queued beats plus the read still in flight never exceed 3, so a new
    // read always finds a free FIFO slot even if the consumer stalls forever.
    always_comb begin
        issue     = (state_q == S_RUN) && ((occ_q + {2'b00, inflight_q}) <= 3'd2);
        last_pix  = (x_q == X_LAST) && (y_q == Y_LAST);
        push      = inflight_q;
        pop       = (occ_q != 3'd0) && bus.m_ready;
        head      = fifo_q[rd_ptr_q];
        push_beat = '{data: bus.mem_rd_data, sof: sof_q, eol: eol_q, eof: eof_q};
        occ_d     = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + 3'd1;
        end else if (pop && !push) begin
            occ_d = occ_q - 3'd1;
        end
    end

    assign bus.mem_rd_en   = issue;
    assign bus.mem_rd_addr = addr_q;
    assign bus.m_valid     = (occ_q != 3'd0);
    assign bus.m_data      = bus.m_valid ? head.data : '0;
    assign bus.m_sof       = bus.m_valid & head.sof;
    assign bus.m_eol       = bus.m_valid & head.eol;
    assign bus.m_eof       = bus.m_valid & head.eof;
    assign busy            = (state_q != S_IDLE);
    assign done            = (state_q == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
            eof_q      <= 1'b0;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            occ_q      <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            inflight_q <= issue;
            occ_q      <= occ_d;

            // Markers travel with the read so they land in the FIFO beside its data.
            if (issue) begin
                sof_q  <= (x_q == '0) && (y_q == '0);
                eol_q  <= (x_q == X_LAST);
                eof_q  <= last_pix;
                addr_q <= addr_q + ADDR_W'(1);
                if (x_q == X_LAST) begin
                    x_q <= '0;
                    y_q <= y_q + YW'(1);
                end else begin
                    x_q <= x_q + XW'(1);
                end
            end

            if (push) begin
                fifo_q[wr_ptr_q] <= push_beat;
                wr_ptr_q         <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        x_q     <= '0;
                        y_q     <= '0;
                        addr_q  <= BASE;
                    end
                end
                S_RUN: begin
                    if (issue && last_pix) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pop && head.eof) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_frame_pixel_reader.sv
//------------------------------------------------------------------------------
// Module   : tb_frame_pixel_reader
// Brief    : Self-checking bench: 4x3 frame reader plus a 1x1 reader at base 100.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_frame_pixel_reader;

    localparam int W_A = 4;
    localparam int H_A = 3;
    localparam int N_A = W_A * H_A;
    localparam int B_BASE = 100;

    typedef struct {
        logic [7:0] d;
        logic       s;
        logic       l;
        logic       f;
        int         cyc;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic busy_a, done_a, busy_b, done_b;

    logic [7:0] ram_a [16];
    logic [7:0] ram_b [256];

    int vectors = 0;
    int miscompares = 0;

    beat_t got[$];
    beat_t exp_q[$];
    int done_cnt, done_cyc, idle_cyc, reads, reads_stall, max_out;
    int stab_err, mark_err, stall_bad;

    frame_pixel_reader_if #(.DATA_W(8), .ADDR_W(4)) bus_a ();
    frame_pixel_reader_if #(.DATA_W(8), .ADDR_W(8)) bus_b ();

    frame_pixel_reader #(
        .WIDTH(W_A), .HEIGHT(H_A), .DATA_W(8), .ADDR_W(4), .BASE_ADDR(0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .busy(busy_a), .done(done_a), .bus(bus_a.master)
    );

    frame_pixel_reader #(
        .WIDTH(1), .HEIGHT(1), .DATA_W(8), .ADDR_W(8), .BASE_ADDR(B_BASE)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .busy(busy_b), .done(done_b), .bus(bus_b.master)
    );

    always #5 clk = ~clk;

    // Synchronous RAMs with one cycle of read latency
    always @(posedge clk) begin
        if (bus_a.mem_rd_en) bus_a.mem_rd_data <= ram_a[bus_a.mem_rd_addr];
        if (bus_b.mem_rd_en) bus_b.mem_rd_data <= ram_b[bus_b.mem_rd_addr];
    end

    // Reference frame: pixel k of the raster, markers from its position.
    function automatic void build_exp();
        beat_t b;
        exp_q.delete();
        for (int k = 0; k < N_A; k++) begin
            b.d   = ram_a[k];
            b.s   = (k == 0);
            b.l   = ((k % W_A) == W_A - 1);
            b.f   = (k == N_A - 1);
            b.cyc = 0;
            exp_q.push_back(b);
        end
    endfunction

    function automatic void fill_ram_a(input bit rnd);
        for (int i = 0; i < 16; i++) begin
            ram_a[i] = rnd ? 8'($urandom) : 8'(i + 8'h10);
        end
    endfunction

    // mode 0: ready held 1, 1: random ready, 2: ready low through cycle 20
    task automatic run_a(input int mode, input bit repulse);
        logic r;
        logic prev_stall;
        logic [10:0] prev;
        int outstanding;
        beat_t b;
        got.delete();
        done_cnt = 0; done_cyc = -1; idle_cyc = -1; reads = 0; reads_stall = 0;
        max_out = 0; stab_err = 0; mark_err = 0; stall_bad = 0;
        prev_stall = 1'b0; prev = '0;
        @(negedge clk);
        start_a = 1'b1;
        bus_a.m_ready = (mode == 0);
        @(posedge clk);
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            start_a = repulse && (cyc == 4 || cyc == 9);
            case (mode)
                0:       r = 1'b1;
                1:       r = 1'($urandom_range(0, 1));
                default: r = (cyc > 20);
            endcase
            bus_a.m_ready = r;
            #1;
            if (bus_a.mem_rd_en) begin
                reads++;
                if (cyc <= 20) reads_stall++;
            end
            outstanding = reads - got.size();
            if (outstanding > max_out) max_out = outstanding;
            if (mode == 2 && cyc >= 3 && cyc <= 20 &&
                (bus_a.m_valid !== 1'b1 || bus_a.m_data !== ram_a[0])) stall_bad++;
            if (prev_stall && (bus_a.m_valid !== 1'b1 ||
                {bus_a.m_data, bus_a.m_sof, bus_a.m_eol} !== prev[10:1] ||
                bus_a.m_eof !== prev[0])) stab_err++;
            if (bus_a.m_valid !== 1'b1 && (bus_a.m_sof || bus_a.m_eol || bus_a.m_eof))
                mark_err++;
            if (bus_a.m_valid === 1'b1 && r) begin
                b.d = bus_a.m_data; b.s = bus_a.m_sof; b.l = bus_a.m_eol;
                b.f = bus_a.m_eof; b.cyc = cyc;
                got.push_back(b);
            end
            prev_stall = (bus_a.m_valid === 1'b1) && !r;
            prev = {bus_a.m_data, bus_a.m_sof, bus_a.m_eol, bus_a.m_eof};
            if (done_a === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (done_cnt > 0 && busy_a === 1'b0) begin
                idle_cyc = cyc;
                break;
            end
        end
        start_a = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy_a, done_a, bus_a.mem_rd_en, bus_a.m_valid, bus_a.m_sof, bus_a.m_eol,
             bus_a.m_eof, bus_a.m_data, busy_b, done_b, bus_b.mem_rd_en, bus_b.m_valid} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: some output nonzero (busy_a=%b valid_a=%b rd_a=%b busy_b=%b), required all 0",
                     busy_a, bus_a.m_valid, bus_a.mem_rd_en, busy_b);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy_a, done_a, bus_a.mem_rd_en, bus_a.m_valid, busy_b, bus_b.m_valid} !== '0) begin
            miscompares++;
            $display("FAIL idle_after_reset: busy_a=%b valid_a=%b rd_a=%b, required 0",
                     busy_a, bus_a.m_valid, bus_a.mem_rd_en);
        end
    endtask

    task automatic test_back_to_back();
        fill_ram_a(1'b0);
        build_exp();
        run_a(0, 1'b0);
        vectors++;
        if (got.size() !== N_A) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d beats, required %0d", got.size(), N_A);
        end
        for (int k = 0; k < N_A; k++) begin
            vectors++;
            if (k >= got.size()) begin
                miscompares++;
                $display("FAIL b2b_beat%0d: missing, required %h", k, exp_q[k].d);
            end else if ({got[k].d, got[k].s, got[k].l, got[k].f} !==
                         {exp_q[k].d, exp_q[k].s, exp_q[k].l, exp_q[k].f} || got[k].cyc !== 3 + k) begin
                miscompares++;
                $display("FAIL b2b_beat%0d: got d=%h sof=%b eol=%b eof=%b cyc=%0d, required d=%h sof=%b eol=%b eof=%b cyc=%0d",
                         k, got[k].d, got[k].s, got[k].l, got[k].f, got[k].cyc,
                         exp_q[k].d, exp_q[k].s, exp_q[k].l, exp_q[k].f, 3 + k);
            end
        end
        vectors++;
        if (done_cnt !== 1 || done_cyc !== N_A + 3 || idle_cyc !== N_A + 4) begin
            miscompares++;
            $display("FAIL b2b_done: done_cnt=%0d done_cyc=%0d idle_cyc=%0d, required 1/%0d/%0d",
                     done_cnt, done_cyc, idle_cyc, N_A + 3, N_A + 4);
        end
        vectors++;
        if (reads !== N_A || mark_err !== 0) begin
            miscompares++;
            $display("FAIL b2b_reads: reads=%0d marker_errs=%0d, required %0d/0", reads, mark_err, N_A);
        end
    endtask

    task automatic test_random_ready();
        int bad;
        for (int it = 0; it < 3; it++) begin
            fill_ram_a(1'b1);
            build_exp();
            run_a(1, 1'b0);
            bad = 0;
            for (int k = 0; k < N_A; k++) begin
                if (k >= got.size() || {got[k].d, got[k].s, got[k].l, got[k].f} !==
                    {exp_q[k].d, exp_q[k].s, exp_q[k].l, exp_q[k].f}) bad++;
            end
            vectors++;
            if (bad !== 0 || got.size() !== N_A) begin
                miscompares++;
                $display("FAIL rand_seq%0d: %0d wrong beats of %0d received, required 0 wrong of %0d",
                         it, bad, got.size(), N_A);
            end
            vectors++;
            if (stab_err !== 0 || mark_err !== 0 || max_out > 4 || done_cnt !== 1) begin
                miscompares++;
                $display("FAIL rand_flow%0d: stab=%0d mark=%0d max_out=%0d done=%0d, required 0/0/<=4/1",
                         it, stab_err, mark_err, max_out, done_cnt);
            end
        end
    endtask

    task automatic test_stall();
        fill_ram_a(1'b0);
        build_exp();
        run_a(2, 1'b0);
        vectors++;
        if (reads_stall > 3 || stall_bad !== 0) begin
            miscompares++;
            $display("FAIL stall_hold: reads during stall=%0d bad_cycles=%0d, required <=3/0",
                     reads_stall, stall_bad);
        end
        vectors++;
        if (got.size() !== N_A || got[0].d !== exp_q[0].d || got[N_A-1].d !== exp_q[N_A-1].d ||
            got[0].cyc !== 21 || got[N_A-1].cyc !== 20 + N_A || stab_err !== 0) begin
            miscompares++;
            $display("FAIL stall_resume: beats=%0d first=%h@%0d last=%h@%0d stab=%0d, required %0d 10@21 1b@%0d 0",
                     got.size(), got.size() > 0 ? got[0].d : 8'h0, got.size() > 0 ? got[0].cyc : -1,
                     got.size() > 0 ? got[got.size()-1].d : 8'h0,
                     got.size() > 0 ? got[got.size()-1].cyc : -1, stab_err, N_A, 20 + N_A);
        end
    endtask

    task automatic test_restart_busy();
        int bad, stray;
        fill_ram_a(1'b1);
        build_exp();
        run_a(0, 1'b1);
        bad = 0;
        for (int k = 0; k < N_A; k++) begin
            if (k >= got.size() || {got[k].d, got[k].s, got[k].l, got[k].f} !==
                {exp_q[k].d, exp_q[k].s, exp_q[k].l, exp_q[k].f}) bad++;
        end
        vectors++;
        if (bad !== 0 || got.size() !== N_A || done_cnt !== 1) begin
            miscompares++;
            $display("FAIL restart_ignored: beats=%0d wrong=%0d done=%0d, required %0d/0/1",
                     got.size(), bad, done_cnt, N_A);
        end
        stray = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy_a !== 1'b0 || bus_a.mem_rd_en !== 1'b0) stray++;
        end
        vectors++;
        if (stray !== 0) begin
            miscompares++;
            $display("FAIL restart_idle: %0d busy/read cycles after done, required 0", stray);
        end
        run_a(0, 1'b0);
        bad = 0;
        for (int k = 0; k < N_A; k++) begin
            if (k >= got.size() || {got[k].d, got[k].s, got[k].l, got[k].f} !==
                {exp_q[k].d, exp_q[k].s, exp_q[k].l, exp_q[k].f}) bad++;
        end
        vectors++;
        if (bad !== 0 || got.size() !== N_A || done_cyc !== N_A + 3) begin
            miscompares++;
            $display("FAIL second_frame: beats=%0d wrong=%0d done_cyc=%0d, required %0d/0/%0d",
                     got.size(), bad, done_cyc, N_A, N_A + 3);
        end
    endtask

    task automatic test_midframe_reset();
        int stray;
        fill_ram_a(1'b1);
        build_exp();
        @(negedge clk);
        start_a = 1'b1;
        bus_a.m_ready = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            start_a = 1'b0;
        end
        #1;
        vectors++;
        if (bus_a.m_valid !== 1'b1 || bus_a.m_data !== exp_q[5].d) begin
            miscompares++;
            $display("FAIL mid_beat5: valid=%b data=%h, required 1/%h", bus_a.m_valid, bus_a.m_data, exp_q[5].d);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy_a, done_a, bus_a.mem_rd_en, bus_a.m_valid, bus_a.m_data,
             bus_a.m_sof, bus_a.m_eol, bus_a.m_eof} !== '0) begin
            miscompares++;
            $display("FAIL mid_async_reset: busy=%b rd=%b valid=%b data=%h, required all 0",
                     busy_a, bus_a.mem_rd_en, bus_a.m_valid, bus_a.m_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus_a.mem_rd_en !== 1'b0 || bus_a.m_valid !== 1'b0 || busy_a !== 1'b0) stray++;
        end
        vectors++;
        if (stray !== 0) begin
            miscompares++;
            $display("FAIL mid_quiet: %0d active cycles after reset, required 0", stray);
        end
        fill_ram_a(1'b0);
        build_exp();
        run_a(0, 1'b0);
        vectors++;
        if (got.size() !== N_A || got[0].d !== 8'h10 || got[0].s !== 1'b1 ||
            got[N_A-1].f !== 1'b1 || done_cnt !== 1) begin
            miscompares++;
            $display("FAIL mid_new_frame: beats=%0d first=%h sof=%b done=%0d, required %0d 10 1 1",
                     got.size(), got.size() > 0 ? got[0].d : 8'h0,
                     got.size() > 0 ? got[0].s : 1'b0, done_cnt, N_A);
        end
    endtask

    task automatic test_single_pixel();
        logic [7:0] v;
        int rd_cnt, beat_cnt, beat_cyc, dn, fin;
        logic [7:0] rd_addr, bd;
        logic [2:0] bm;
        v = 8'($urandom);
        ram_b[B_BASE] = v;
        rd_cnt = 0; beat_cnt = 0; beat_cyc = -1; dn = 0; fin = 0;
        rd_addr = '0; bd = '0; bm = '0;
        @(negedge clk);
        start_b = 1'b1;
        bus_b.m_ready = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            start_b = 1'b0;
            #1;
            if (bus_b.mem_rd_en === 1'b1) begin
                rd_cnt++;
                rd_addr = bus_b.mem_rd_addr;
            end
            if (bus_b.m_valid === 1'b1) begin
                beat_cnt++;
                beat_cyc = cyc;
                bd = bus_b.m_data;
                bm = {bus_b.m_sof, bus_b.m_eol, bus_b.m_eof};
            end
            if (done_b === 1'b1) dn++;
            if (dn > 0 && busy_b === 1'b0) begin
                fin = 1;
                break;
            end
        end
        vectors++;
        if (rd_cnt !== 1 || rd_addr !== 8'(B_BASE)) begin
            miscompares++;
            $display("FAIL single_read: reads=%0d addr=%0d, required 1/%0d", rd_cnt, rd_addr, B_BASE);
        end
        vectors++;
        if (beat_cnt !== 1 || bd !== v || bm !== 3'b111 || beat_cyc !== 3) begin
            miscompares++;
            $display("FAIL single_beat: beats=%0d data=%h markers=%b cyc=%0d, required 1/%h/111/3",
                     beat_cnt, bd, bm, beat_cyc, v);
        end
        vectors++;
        if (dn !== 1 || fin !== 1) begin
            miscompares++;
            $display("FAIL single_done: done=%0d finished=%0d, required 1/1", dn, fin);
        end
    endtask

    initial begin
        bus_a.m_ready = 1'b0;
        bus_b.m_ready = 1'b0;
        for (int i = 0; i < 256; i++) ram_b[i] = 8'(i);
        fill_ram_a(1'b0);
        test_reset();
        test_back_to_back();
        test_random_ready();
        test_stall();
        test_restart_busy();
        test_midframe_reset();
        test_single_pixel();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
